// File: rtl/axis_burst_probe.sv
// axis_burst_probe
//   Sits between the XDMA AXI-Stream pair and a DUT. A request packet
//   (header + VIP2DUT_WORDS_NUM data words) atomically updates the DUT input
//   bus and gives a cycle count N. The probe then enables the DUT clock for N
//   cycles, waits SETTLE_CYCLES, captures the DUT output bus and returns a
//   status word followed by DUT2VIP_WORDS_NUM captured words.
//   Malformed packets are dropped and counted without touching the DUT.
//
// Ports
//   s_axis_aclk / s_axis_aresetn : clock, async active-low reset
//   s_axis_*                     : request stream (tkeep ignored)
//   m_axis_*                     : response stream (tkeep all ones)
//   vip2dut_bus                  : DUT inputs, word k at [k*C_DATA_WIDTH +: C_DATA_WIDTH]
//   vip2dut_clk_en               : registered enable for the DUT clock buffer
//   dut2vip_bus                  : DUT outputs, slice k returned as response word k+1
//   s_axis_bad_packet            : one-cycle pulse per dropped packet
//   busy                         : high whenever the probe is not accepting a request
module axis_burst_probe #(
  parameter int C_DATA_WIDTH      = 128,
  parameter int VIP2DUT_WORDS_NUM = 10,
  parameter int DUT2VIP_WORDS_NUM = 10,
  parameter int CYCLES_W          = 16,
  parameter int SETTLE_CYCLES     = 1
) (
  input  logic                                        s_axis_aclk,
  input  logic                                        s_axis_aresetn,
  input  logic                                        s_axis_tvalid,
  output logic                                        s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]                     s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]                   s_axis_tkeep,
  input  logic                                        s_axis_tlast,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]                     m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]                   m_axis_tkeep,
  output logic                                        m_axis_tlast,
  output logic [C_DATA_WIDTH*VIP2DUT_WORDS_NUM-1:0]   vip2dut_bus,
  output logic                                        vip2dut_clk_en,
  input  logic [C_DATA_WIDTH*DUT2VIP_WORDS_NUM-1:0]   dut2vip_bus,
  output logic                                        s_axis_bad_packet,
  output logic                                        busy
);

  localparam int W   = C_DATA_WIDTH;
  localparam int V   = VIP2DUT_WORDS_NUM;
  localparam int D   = DUT2VIP_WORDS_NUM;
  localparam int WCW = $clog2(V + 1);
  localparam int RCW = $clog2(D + 1);
  localparam int SCW = $clog2(SETTLE_CYCLES + 1) + 1;

  typedef enum logic [2:0] {S_RX, S_DISCARD, S_RUN, S_SETTLE, S_CAP, S_TX} state_t;

  // Where execution continues once the clock-enable phase is over (or skipped).
  localparam state_t POST_RUN = (SETTLE_CYCLES > 0) ? S_SETTLE : S_CAP;

  state_t               state, state_nxt;
  logic [WCW-1:0]       word_cnt;
  logic [CYCLES_W-1:0]  n_q, run_cnt;
  logic [SCW-1:0]       settle_cnt;
  logic [RCW-1:0]       rsp_cnt, rsp_cnt_nxt;
  logic [V-1:0][W-1:0]  shadow_q, shadow_d, vip_q;
  logic [D-1:0][W-1:0]  cap_q;
  logic [15:0]          seq, bad_cnt;
  logic                 s_hs, m_hs, good_evt, bad_evt;
  logic [W-1:0]         tdata_nxt;
  logic                 unused_tkeep;

  assign unused_tkeep  = ^s_axis_tkeep;
  assign s_axis_tready = (state == S_RX) || (state == S_DISCARD);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_hs          = m_axis_tvalid && m_axis_tready;
  assign m_axis_tkeep  = '1;
  assign vip2dut_bus   = vip_q;

  // Next state, request classification and shadow write.
  always_comb begin
    state_nxt   = state;
    good_evt    = 1'b0;
    bad_evt     = 1'b0;
    rsp_cnt_nxt = rsp_cnt;
    shadow_d    = shadow_q;
    case (state)
      S_RX: if (s_hs) begin
        for (int k = 0; k < V; k++)
          if (word_cnt == WCW'(k + 1)) shadow_d[k] = s_axis_tdata;
        if (word_cnt == WCW'(V)) begin
          if (s_axis_tlast) begin
            good_evt  = 1'b1;
            state_nxt = (n_q != '0) ? S_RUN : POST_RUN;
          end else begin
            bad_evt   = 1'b1;
            state_nxt = S_DISCARD;
          end
        end else if (s_axis_tlast) begin
          bad_evt = 1'b1;
        end
      end
      S_DISCARD: if (s_hs && s_axis_tlast) state_nxt = S_RX;
      S_RUN:     if (run_cnt == CYCLES_W'(1)) state_nxt = POST_RUN;
      S_SETTLE:  if (settle_cnt == SCW'(1)) state_nxt = S_CAP;
      S_CAP: begin
        state_nxt   = S_TX;
        rsp_cnt_nxt = '0;
      end
      S_TX: if (m_hs) begin
        if (rsp_cnt == RCW'(D)) state_nxt = S_RX;
        else                    rsp_cnt_nxt = rsp_cnt + 1'b1;
      end
      default: state_nxt = S_RX;
    endcase
  end

  // Response word for the next cycle; recomputed from the held rsp_cnt while
  // stalled, so tdata stays put under backpressure.
  always_comb begin
    tdata_nxt = '0;
    if (state_nxt == S_TX) begin
      if (rsp_cnt_nxt == '0) begin
        tdata_nxt[15:0]  = 16'(n_q);
        tdata_nxt[31:16] = seq;
        tdata_nxt[47:32] = bad_cnt;
      end else begin
        for (int j = 0; j < D; j++)
          if (rsp_cnt_nxt == RCW'(j + 1)) tdata_nxt = cap_q[j];
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state             <= S_RX;
      word_cnt          <= '0;
      n_q               <= '0;
      run_cnt           <= '0;
      settle_cnt        <= '0;
      rsp_cnt           <= '0;
      shadow_q          <= '0;
      vip_q             <= '0;
      cap_q             <= '0;
      seq               <= '0;
      bad_cnt           <= '0;
      s_axis_bad_packet <= 1'b0;
      vip2dut_clk_en    <= 1'b0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      m_axis_tdata      <= '0;
      busy              <= 1'b0;
    end else begin
      state    <= state_nxt;
      rsp_cnt  <= rsp_cnt_nxt;
      shadow_q <= shadow_d;

      if (state == S_RX && s_hs) begin
        if (word_cnt == '0) n_q <= s_axis_tdata[CYCLES_W-1:0];
        word_cnt <= (word_cnt == WCW'(V) || s_axis_tlast) ? '0 : word_cnt + 1'b1;
      end

      // Commit takes the last data word straight from the bus on this edge.
      if (good_evt) begin
        vip_q   <= shadow_d;
        seq     <= seq + 16'd1;
        run_cnt <= n_q;
      end else if (state == S_RUN) begin
        run_cnt <= run_cnt - 1'b1;
      end

      if (state_nxt == S_SETTLE && state != S_SETTLE) settle_cnt <= SCW'(SETTLE_CYCLES);
      else if (state == S_SETTLE)                     settle_cnt <= settle_cnt - 1'b1;

      if (state == S_CAP) cap_q <= dut2vip_bus;

      s_axis_bad_packet <= bad_evt;
      if (bad_evt && bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;

      vip2dut_clk_en <= (state_nxt == S_RUN);
      m_axis_tvalid  <= (state_nxt == S_TX);
      m_axis_tlast   <= (state_nxt == S_TX) && (rsp_cnt_nxt == RCW'(D));
      m_axis_tdata   <= tdata_nxt;
      busy           <= (state_nxt != S_RX);
    end
  end

endmodule

// File: tb/tb_axis_burst_probe.sv
`timescale 1ns/1ps
module tb_axis_burst_probe;
  localparam int W  = 64;
  localparam int V  = 2;
  localparam int D  = 3;
  localparam int S  = 1;
  localparam int CW = 16;

  logic             clk = 1'b0, rstn = 1'b0;
  logic             s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [W-1:0]     s_tdata = '0;
  logic [W/8-1:0]   s_tkeep = '1;
  logic             m_tvalid, m_tready = 1'b1, m_tlast;
  logic [W-1:0]     m_tdata;
  logic [W/8-1:0]   m_tkeep;
  logic [W*V-1:0]   vip_bus;
  logic             clk_en, bad, busy;
  logic [W*D-1:0]   dut_bus = '0;

  axis_burst_probe #(.C_DATA_WIDTH(W), .VIP2DUT_WORDS_NUM(V), .DUT2VIP_WORDS_NUM(D),
                     .CYCLES_W(CW), .SETTLE_CYCLES(S)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rstn),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .vip2dut_bus(vip_bus), .vip2dut_clk_en(clk_en), .dut2vip_bus(dut_bus),
    .s_axis_bad_packet(bad), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Cycle bookkeeping: edge_n counts rising edges; a cycle is numbered by the
  // edge that opens it plus one, so "cycle t+1" follows handshake edge t.
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int ce_total = 0, tv_total = 0, bad_total = 0;
  int ce_rise = -1, ce_last = -1, tv_rise = -1, bad_last = -1;
  bit pce = 1'b0, ptv = 1'b0;
  always @(negedge clk) begin
    pce <= clk_en;
    ptv <= m_tvalid;
    if (clk_en) begin
      ce_total <= ce_total + 1;
      ce_last  <= edge_n + 1;
      if (!pce) ce_rise <= edge_n + 1;
    end
    if (m_tvalid) begin
      tv_total <= tv_total + 1;
      if (!ptv) tv_rise <= edge_n + 1;
    end
    if (bad) begin
      bad_total <= bad_total + 1;
      bad_last  <= edge_n + 1;
    end
  end

  // Reference model state
  logic [15:0]  m_seq = '0, m_bad = '0;
  logic [W-1:0] m_vip [V];
  logic [W-1:0] exp_w [D+1];
  logic [W-1:0] pkt_w [8];
  int           pkt_t [8];
  logic [W-1:0] rx_d [8];
  bit           rx_l [8];

  int g_t, g_waits, g_n, g_hold, g_str, g_ce0, g_tv0;
  bit g_done, g_sr_after, g_tv_after;
  logic [W*V-1:0] g_vip;

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  // Offer one word starting mid-cycle; returns the handshake edge number.
  task automatic send_word(input logic [W-1:0] d, input bit last, output int t, output int waits);
    bit rdy;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
    waits = 0; t = -1;
    for (int i = 0; i < 100; i++) begin
      rdy = s_tready;
      @(posedge clk); #1;
      if (rdy) begin t = edge_n; break; end
      waits++;
      @(negedge clk);
    end
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (t < 0) waits = 999;
  endtask

  task automatic send_pkt(input int len, input logic [15:0] n, output int t_end, output int waits);
    logic [W-1:0] h;
    int t, w;
    h = rnd(); h[15:0] = n; pkt_w[0] = h;
    for (int i = 1; i < len; i++) pkt_w[i] = rnd();
    waits = 0; t_end = -1;
    for (int i = 0; i < len; i++) begin
      send_word(pkt_w[i], i == len - 1, t, w);
      pkt_t[i] = t; waits += w; t_end = t;
    end
  endtask

  // Packet-level rules: exactly V+1 words is good, anything else is dropped.
  task automatic model_pkt(input int len, input logic [15:0] n);
    if (len == V + 1) begin
      m_seq = m_seq + 16'd1;
      for (int k = 0; k < V; k++) m_vip[k] = pkt_w[k + 1];
      exp_w[0] = {16'h0, m_bad, m_seq, n};
      for (int j = 1; j <= D; j++) exp_w[j] = dut_bus[(j - 1) * W +: W];
    end else if (m_bad != 16'hFFFF) begin
      m_bad = m_bad + 16'd1;
    end
  endtask

  task automatic collect(input bit bp, output int n, output int hold_bad, output int str_bad, output bit done);
    logic [W-1:0] pd;
    bit pl, stall, tog;
    n = 0; hold_bad = 0; str_bad = 0; done = 1'b0; stall = 1'b0; tog = 1'b0; pd = '0; pl = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (s_tready) str_bad++;
      if (m_tvalid) begin
        if (stall && (m_tdata !== pd || m_tlast !== pl)) hold_bad++;
        m_tready = bp ? tog : 1'b1;
        tog = !tog;
        if (m_tready) begin
          if (n < 8) begin rx_d[n] = m_tdata; rx_l[n] = m_tlast; end
          n++; stall = 1'b0;
          if (m_tlast) done = 1'b1;
        end else begin
          stall = 1'b1; pd = m_tdata; pl = m_tlast;
        end
      end
      @(negedge clk);
    end
    m_tready = 1'b1;
  endtask

  task automatic run_good(input logic [15:0] n, input bit bp);
    dut_bus = {rnd(), rnd(), rnd()};
    g_ce0 = ce_total; g_tv0 = tv_total;
    send_pkt(V + 1, n, g_t, g_waits);
    model_pkt(V + 1, n);
    g_vip = vip_bus;
    collect(bp, g_n, g_hold, g_str, g_done);
    g_sr_after = s_tready; g_tv_after = m_tvalid;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_s_tready: got %b want 1", s_tready); end
    checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin errors++; $display("FAIL rst_m_valid_last: got %b/%b want 0/0", m_tvalid, m_tlast); end
    checks++; if (m_tdata !== '0) begin errors++; $display("FAIL rst_m_tdata: got %h want 0", m_tdata); end
    checks++; if (vip_bus !== '0) begin errors++; $display("FAIL rst_vip_bus: got %h want 0", vip_bus); end
    checks++; if (clk_en !== 1'b0 || bad !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_ce_bad_busy: got %b%b%b want 000", clk_en, bad, busy); end
    checks++; if (m_tkeep !== 8'hFF) begin errors++; $display("FAIL rst_tkeep: got %h want ff", m_tkeep); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || s_tready !== 1'b1) begin errors++; $display("FAIL post_rst_idle: busy=%b tready=%b want 0/1", busy, s_tready); end
  endtask

  task automatic test_good();
    run_good(16'd3, 1'b0);
    checks++; if (g_waits != 0) begin errors++; $display("FAIL good_req_stalls: got %0d want 0", g_waits); end
    checks++; if (g_vip !== {pkt_w[2], pkt_w[1]}) begin errors++; $display("FAIL good_vip_bus: got %h want %h", g_vip, {pkt_w[2], pkt_w[1]}); end
    checks++; if (ce_total - g_ce0 != 3) begin errors++; $display("FAIL good_ce_count: got %0d want 3", ce_total - g_ce0); end
    checks++; if (ce_rise != g_t + 1 || ce_last != g_t + 3) begin errors++; $display("FAIL good_ce_window: got %0d..%0d want %0d..%0d", ce_rise, ce_last, g_t + 1, g_t + 3); end
    checks++; if (tv_rise != g_t + 3 + S + 2) begin errors++; $display("FAIL good_tvalid_latency: got %0d want %0d", tv_rise, g_t + 3 + S + 2); end
    checks++; if (!g_done || g_n != D + 1) begin errors++; $display("FAIL good_rsp_len: got %0d done=%0b want %0d", g_n, g_done, D + 1); end
    checks++; if (rx_d[0] !== 64'h0000_0000_0001_0003) begin errors++; $display("FAIL good_status: got %h want 0000000000010003", rx_d[0]); end
    for (int j = 1; j <= D; j++) begin
      checks++;
      if (rx_d[j] !== exp_w[j] || rx_l[j] !== (j == D)) begin errors++; $display("FAIL good_word%0d: got %h last=%0b want %h last=%0b", j, rx_d[j], rx_l[j], exp_w[j], j == D); end
    end
    checks++; if (rx_l[0] !== 1'b0) begin errors++; $display("FAIL good_status_last: got 1 want 0"); end
    checks++; if (g_sr_after !== 1'b1 || g_tv_after !== 1'b0) begin errors++; $display("FAIL good_after: tready=%b tvalid=%b want 1/0", g_sr_after, g_tv_after); end
  endtask

  task automatic test_zero_cycle();
    run_good(16'd0, 1'b0);
    checks++; if (ce_total != g_ce0) begin errors++; $display("FAIL zero_ce: got %0d cycles want 0", ce_total - g_ce0); end
    checks++; if (tv_rise != g_t + 3) begin errors++; $display("FAIL zero_latency: got %0d want %0d", tv_rise, g_t + 3); end
    checks++; if (!g_done || rx_d[0] !== exp_w[0]) begin errors++; $display("FAIL zero_status: got %h want %h", rx_d[0], exp_w[0]); end
    checks++; if (rx_d[0][31:16] !== 16'd2) begin errors++; $display("FAIL zero_seq: got %0d want 2", rx_d[0][31:16]); end
  endtask

  task automatic test_short();
    int b0, tv0, ce0, t, w;
    b0 = bad_total; tv0 = tv_total; ce0 = ce_total;
    send_pkt(2, 16'($urandom_range(1, 9)), t, w);
    model_pkt(2, 16'd0);
    repeat (4) @(negedge clk);
    checks++; if (bad_total - b0 != 1 || bad_last != t + 1) begin errors++; $display("FAIL short_pulse: got %0d at %0d want 1 at %0d", bad_total - b0, bad_last, t + 1); end
    checks++; if (vip_bus !== {m_vip[1], m_vip[0]}) begin errors++; $display("FAIL short_vip: got %h want %h", vip_bus, {m_vip[1], m_vip[0]}); end
    checks++; if (tv_total != tv0 || ce_total != ce0 || w != 0) begin errors++; $display("FAIL short_side: tv=%0d ce=%0d stalls=%0d want 0/0/0", tv_total - tv0, ce_total - ce0, w); end
    run_good(16'd2, 1'b0);
    checks++; if (!g_done || rx_d[0][47:32] !== 16'd1 || rx_d[0] !== exp_w[0]) begin errors++; $display("FAIL short_next_status: got %h want %h", rx_d[0], exp_w[0]); end
  endtask

  task automatic test_long();
    int b0, tv0, ce0, t, w;
    b0 = bad_total; tv0 = tv_total; ce0 = ce_total;
    send_pkt(5, 16'd4, t, w);
    model_pkt(5, 16'd0);
    repeat (4) @(negedge clk);
    checks++; if (bad_total - b0 != 1 || bad_last != pkt_t[V] + 1) begin errors++; $display("FAIL long_pulse: got %0d at %0d want 1 at %0d", bad_total - b0, bad_last, pkt_t[V] + 1); end
    checks++; if (w != 0) begin errors++; $display("FAIL long_stalls: got %0d want 0", w); end
    checks++; if (tv_total != tv0 || ce_total != ce0) begin errors++; $display("FAIL long_side: tv=%0d ce=%0d want 0/0", tv_total - tv0, ce_total - ce0); end
    checks++; if (vip_bus !== {m_vip[1], m_vip[0]} || s_tready !== 1'b1) begin errors++; $display("FAIL long_vip_rdy: got %h rdy=%b want %h rdy=1", vip_bus, s_tready, {m_vip[1], m_vip[0]}); end
  endtask

  task automatic test_backpressure();
    run_good(16'($urandom_range(1, 4)), 1'b1);
    checks++; if (!g_done || g_n != D + 1) begin errors++; $display("FAIL bp_len: got %0d done=%0b want %0d", g_n, g_done, D + 1); end
    for (int j = 0; j <= D; j++) begin
      checks++;
      if (rx_d[j] !== exp_w[j] || rx_l[j] !== (j == D)) begin errors++; $display("FAIL bp_word%0d: got %h last=%0b want %h last=%0b", j, rx_d[j], rx_l[j], exp_w[j], j == D); end
    end
    checks++; if (g_hold != 0) begin errors++; $display("FAIL bp_hold: got %0d changes want 0", g_hold); end
    checks++; if (g_str != 0 || g_sr_after !== 1'b1) begin errors++; $display("FAIL bp_s_tready: early=%0d after=%b want 0/1", g_str, g_sr_after); end
  endtask

  task automatic test_random();
    logic [15:0] n;
    for (int it = 0; it < 5; it++) begin
      n = 16'($urandom_range(0, 6));
      run_good(n, 1'($urandom_range(0, 1)));
      checks++; if (ce_total - g_ce0 != int'(n)) begin errors++; $display("FAIL rnd%0d_ce: got %0d want %0d", it, ce_total - g_ce0, n); end
      checks++; if (tv_rise != g_t + int'(n) + S + 2) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, tv_rise, g_t + int'(n) + S + 2); end
      for (int j = 0; j <= D; j++) begin
        checks++;
        if (!g_done || rx_d[j] !== exp_w[j] || rx_l[j] !== (j == D)) begin errors++; $display("FAIL rnd%0d_word%0d: got %h want %h", it, j, rx_d[j], exp_w[j]); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int t, w, cnt;
    dut_bus = {rnd(), rnd(), rnd()};
    send_pkt(V + 1, 16'd100, t, w);
    model_pkt(V + 1, 16'd100);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (clk_en) cnt++;
      if (cnt == 10) break;
      @(negedge clk);
    end
    checks++; if (cnt != 10) begin errors++; $display("FAIL midrun_ce_reach: got %0d want 10", cnt); end
    rstn = 1'b0;
    m_seq = '0; m_bad = '0;
    for (int k = 0; k < V; k++) m_vip[k] = '0;
    #1;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL midrun_ce_drop: got %b want 0", clk_en); end
    checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0) begin errors++; $display("FAIL midrun_m_rst: got %b %b %h want 0 0 0", m_tvalid, m_tlast, m_tdata); end
    checks++; if (vip_bus !== {m_vip[1], m_vip[0]} || bad !== 1'b0 || busy !== 1'b0 || s_tready !== 1'b1) begin errors++; $display("FAIL midrun_outs: vip=%h bad=%b busy=%b rdy=%b", vip_bus, bad, busy, s_tready); end
    @(negedge clk); rstn = 1'b1; @(negedge clk);
    run_good(16'd5, 1'b0);
    checks++; if (!g_done || rx_d[0] !== 64'h0000_0000_0001_0005 || rx_d[0] !== exp_w[0]) begin errors++; $display("FAIL midrun_next_status: got %h want 0000000000010005", rx_d[0]); end
    checks++; if (ce_total - g_ce0 != 5 || rx_d[D] !== exp_w[D]) begin errors++; $display("FAIL midrun_next_run: ce=%0d word=%h want 5 %h", ce_total - g_ce0, rx_d[D], exp_w[D]); end
  endtask

  initial begin
    for (int k = 0; k < V; k++) m_vip[k] = '0;
    test_reset();
    test_good();
    test_zero_cycle();
    test_short();
    test_long();
    test_backpressure();
    test_random();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
